// File: rtl/tdm_demux4_if.sv
// Bus bundle between the shared TDM stream, the demultiplexer and its four consumers.
// The master side drives the sample stream and observes the recovered channels.
interface tdm_demux4_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic [WIDTH-1:0] in_data;
    logic             frame_sync;

    logic [WIDTH-1:0] out0;
    logic [WIDTH-1:0] out1;
    logic [WIDTH-1:0] out2;
    logic [WIDTH-1:0] out3;
    logic [3:0]       valid;
    logic [1:0]       slot;
    logic             locked;
    logic             frame_done;
    logic             sync_err;

    modport master (
        output in_valid, in_data, frame_sync,
        input  out0, out1, out2, out3, valid, slot, locked, frame_done, sync_err
    );

    modport slave (
        input  in_valid, in_data, frame_sync,
        output out0, out1, out2, out3, valid, slot, locked, frame_done, sync_err
    );
endinterface

// File: rtl/tdm_demux4.sv
// Receive end of the 4-channel TDM link: locks onto the frame marker and splits the
// shared sample stream into four registered, holding channel outputs.
module tdm_demux4 #(
    parameter int WIDTH = 8
) (
    input  logic         clk,
    input  logic         rst,
    tdm_demux4_if.slave  bus
);
    localparam logic [0:0] HUNT   = 1'b0;
    localparam logic [0:0] LOCKED = 1'b1;

    logic [0:0]       state;
    logic [0:0]       next_state;
    logic [1:0]       slot_q;
    logic [1:0]       next_slot;
    logic [WIDTH-1:0] chan_q [4];
    logic [3:0]       valid_q;
    logic             frame_done_q;
    logic             sync_err_q;

    logic             wr_en;
    logic [1:0]       wr_idx;
    logic             set_done;
    logic             set_err;

    // A frame marker always restarts at channel 0; in LOCKED it is only an error
    // when it arrives before the current frame has wrapped back to slot 0.
    always_comb begin
        next_state = state;
        next_slot  = slot_q;
        wr_en      = 1'b0;
        wr_idx     = slot_q;
        set_done   = 1'b0;
        set_err    = 1'b0;
        if (bus.in_valid) begin
            if (state == HUNT) begin
                if (bus.frame_sync) begin
                    wr_en      = 1'b1;
                    wr_idx     = 2'd0;
                    next_slot  = 2'd1;
                    next_state = LOCKED;
                end
            end else begin
                if (bus.frame_sync) begin
                    wr_en     = 1'b1;
                    wr_idx    = 2'd0;
                    next_slot = 2'd1;
                    set_err   = (slot_q != 2'd0);
                end else if (slot_q != 2'd0) begin
                    wr_en     = 1'b1;
                    wr_idx    = slot_q;
                    next_slot = slot_q + 2'd1;
                    set_done  = (slot_q == 2'd3);
                end else begin
                    set_err    = 1'b1;
                    next_slot  = 2'd0;
                    next_state = HUNT;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= HUNT;
            slot_q       <= 2'd0;
            valid_q      <= 4'd0;
            frame_done_q <= 1'b0;
            sync_err_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                chan_q[i] <= '0;
            end
        end else begin
            state        <= next_state;
            slot_q       <= next_slot;
            frame_done_q <= set_done;
            sync_err_q   <= set_err;
            valid_q      <= wr_en ? (4'b0001 << wr_idx) : 4'b0000;
            if (wr_en) begin
                chan_q[wr_idx] <= bus.in_data;
            end
        end
    end

    assign bus.out0       = chan_q[0];
    assign bus.out1       = chan_q[1];
    assign bus.out2       = chan_q[2];
    assign bus.out3       = chan_q[3];
    assign bus.valid      = valid_q;
    assign bus.slot       = slot_q;
    assign bus.locked     = (state == LOCKED);
    assign bus.frame_done = frame_done_q;
    assign bus.sync_err   = sync_err_q;
endmodule

// File: tb/tb_tdm_demux4.sv
// Directed bench for tdm_demux4: reset, frame lock, hunt discard, gaps, early and
// missing frame markers, with hand-computed expected values.
module tb_tdm_demux4;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    tdm_demux4_if #(.WIDTH(8)) bus ();

    tdm_demux4 #(.WIDTH(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drives one sample for exactly one rising edge, then samples 1 time unit later.
    task automatic send(input logic sync, input logic [7:0] data);
        bus.in_valid   = 1'b1;
        bus.frame_sync = sync;
        bus.in_data    = data;
        @(posedge clk);
        #1;
        bus.in_valid   = 1'b0;
        bus.frame_sync = 1'b0;
        bus.in_data    = 8'h00;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        do_reset();
        send(1'b1, 8'h11);
        send(1'b0, 8'h22);
        send(1'b0, 8'h33);
        checks++;
        if (bus.out2 !== 8'h33) begin
            errors++; $display("[TB] FAIL reset_pre_out2 got %h want 33", bus.out2);
        end
        #1;
        rst = 1'b1;
        #1;
        checks++;
        if ({bus.out0, bus.out1, bus.out2, bus.out3} !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_outs got %h want 0", {bus.out0, bus.out1, bus.out2, bus.out3});
        end
        checks++;
        if ({bus.valid, bus.slot, bus.locked, bus.frame_done, bus.sync_err} !== 9'h0) begin
            errors++; $display("[TB] FAIL reset_status got valid=%b slot=%0d locked=%b fd=%b se=%b want all 0",
                               bus.valid, bus.slot, bus.locked, bus.frame_done, bus.sync_err);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_lock_frame();
        do_reset();
        send(1'b1, 8'hA0);
        checks++;
        if (bus.valid !== 4'b0001 || bus.out0 !== 8'hA0 || bus.locked !== 1'b1 || bus.slot !== 2'd1) begin
            errors++; $display("[TB] FAIL lock_ch0 got valid=%b out0=%h locked=%b slot=%0d want 0001 a0 1 1",
                               bus.valid, bus.out0, bus.locked, bus.slot);
        end
        send(1'b0, 8'hB1);
        checks++;
        if (bus.valid !== 4'b0010 || bus.out1 !== 8'hB1 || bus.slot !== 2'd2) begin
            errors++; $display("[TB] FAIL lock_ch1 got valid=%b out1=%h slot=%0d want 0010 b1 2",
                               bus.valid, bus.out1, bus.slot);
        end
        send(1'b0, 8'hC2);
        checks++;
        if (bus.valid !== 4'b0100 || bus.out2 !== 8'hC2 || bus.frame_done !== 1'b0) begin
            errors++; $display("[TB] FAIL lock_ch2 got valid=%b out2=%h fd=%b want 0100 c2 0",
                               bus.valid, bus.out2, bus.frame_done);
        end
        send(1'b0, 8'hD3);
        checks++;
        if (bus.valid !== 4'b1000 || bus.out3 !== 8'hD3 || bus.frame_done !== 1'b1 || bus.slot !== 2'd0) begin
            errors++; $display("[TB] FAIL lock_ch3 got valid=%b out3=%h fd=%b slot=%0d want 1000 d3 1 0",
                               bus.valid, bus.out3, bus.frame_done, bus.slot);
        end
        checks++;
        if ({bus.out0, bus.out1, bus.out2, bus.out3} !== 32'hA0B1C2D3 || bus.locked !== 1'b1) begin
            errors++; $display("[TB] FAIL lock_frame_outs got %h locked=%b want a0b1c2d3 1",
                               {bus.out0, bus.out1, bus.out2, bus.out3}, bus.locked);
        end
        idle(1);
        checks++;
        if (bus.valid !== 4'b0000 || bus.frame_done !== 1'b0) begin
            errors++; $display("[TB] FAIL lock_pulse_clear got valid=%b fd=%b want 0000 0", bus.valid, bus.frame_done);
        end
    endtask

    task automatic test_hunt_discard();
        do_reset();
        send(1'b0, 8'h11);
        checks++;
        if (bus.valid !== 4'b0000 || bus.sync_err !== 1'b0 || bus.locked !== 1'b0 || bus.out0 !== 8'h00) begin
            errors++; $display("[TB] FAIL hunt_first got valid=%b se=%b locked=%b out0=%h want 0000 0 0 00",
                               bus.valid, bus.sync_err, bus.locked, bus.out0);
        end
        send(1'b0, 8'h22);
        checks++;
        if (bus.valid !== 4'b0000 || bus.sync_err !== 1'b0 || bus.slot !== 2'd0) begin
            errors++; $display("[TB] FAIL hunt_second got valid=%b se=%b slot=%0d want 0000 0 0",
                               bus.valid, bus.sync_err, bus.slot);
        end
        send(1'b1, 8'h44);
        checks++;
        if (bus.out0 !== 8'h44 || bus.slot !== 2'd1 || bus.valid !== 4'b0001 || bus.locked !== 1'b1) begin
            errors++; $display("[TB] FAIL hunt_lock got out0=%h slot=%0d valid=%b locked=%b want 44 1 0001 1",
                               bus.out0, bus.slot, bus.valid, bus.locked);
        end
        checks++;
        if (bus.out1 !== 8'h00) begin
            errors++; $display("[TB] FAIL hunt_out1 got %h want 00", bus.out1);
        end
    endtask

    task automatic test_gaps();
        do_reset();
        send(1'b1, 8'h01);
        idle(3);
        checks++;
        if (bus.valid !== 4'b0000 || bus.out0 !== 8'h01 || bus.slot !== 2'd1) begin
            errors++; $display("[TB] FAIL gap1_hold got valid=%b out0=%h slot=%0d want 0000 01 1",
                               bus.valid, bus.out0, bus.slot);
        end
        send(1'b0, 8'h02);
        checks++;
        if (bus.valid !== 4'b0010 || bus.out1 !== 8'h02) begin
            errors++; $display("[TB] FAIL gap_ch1 got valid=%b out1=%h want 0010 02", bus.valid, bus.out1);
        end
        bus.frame_sync = 1'b1;
        idle(3);
        bus.frame_sync = 1'b0;
        checks++;
        if (bus.slot !== 2'd2 || bus.sync_err !== 1'b0 || bus.valid !== 4'b0000 || bus.out0 !== 8'h01) begin
            errors++; $display("[TB] FAIL gap_sync_ignored got slot=%0d se=%b valid=%b out0=%h want 2 0 0000 01",
                               bus.slot, bus.sync_err, bus.valid, bus.out0);
        end
        send(1'b0, 8'h03);
        idle(3);
        checks++;
        if (bus.valid !== 4'b0000 || bus.out2 !== 8'h03 || bus.slot !== 2'd3) begin
            errors++; $display("[TB] FAIL gap3_hold got valid=%b out2=%h slot=%0d want 0000 03 3",
                               bus.valid, bus.out2, bus.slot);
        end
        send(1'b0, 8'h04);
        checks++;
        if (bus.valid !== 4'b1000 || bus.frame_done !== 1'b1 || {bus.out0, bus.out1, bus.out2, bus.out3} !== 32'h01020304) begin
            errors++; $display("[TB] FAIL gap_frame got valid=%b fd=%b outs=%h want 1000 1 01020304",
                               bus.valid, bus.frame_done, {bus.out0, bus.out1, bus.out2, bus.out3});
        end
    endtask

    // Relies on test_gaps having left out2=03, out3=04 and slot=0 while locked.
    task automatic test_early_sync();
        send(1'b1, 8'h10);
        send(1'b0, 8'h20);
        checks++;
        if (bus.sync_err !== 1'b0 || bus.slot !== 2'd2) begin
            errors++; $display("[TB] FAIL early_pre got se=%b slot=%0d want 0 2", bus.sync_err, bus.slot);
        end
        send(1'b1, 8'h30);
        checks++;
        if (bus.sync_err !== 1'b1 || bus.valid !== 4'b0001 || bus.slot !== 2'd1 || bus.frame_done !== 1'b0) begin
            errors++; $display("[TB] FAIL early_flags got se=%b valid=%b slot=%0d fd=%b want 1 0001 1 0",
                               bus.sync_err, bus.valid, bus.slot, bus.frame_done);
        end
        checks++;
        if ({bus.out0, bus.out1, bus.out2, bus.out3} !== 32'h30200304 || bus.locked !== 1'b1) begin
            errors++; $display("[TB] FAIL early_outs got %h locked=%b want 30200304 1",
                               {bus.out0, bus.out1, bus.out2, bus.out3}, bus.locked);
        end
        idle(1);
        checks++;
        if (bus.sync_err !== 1'b0) begin
            errors++; $display("[TB] FAIL early_pulse_clear got se=%b want 0", bus.sync_err);
        end
    endtask

    task automatic test_missing_sync();
        do_reset();
        send(1'b1, 8'hA1);
        send(1'b0, 8'hA2);
        send(1'b0, 8'hA3);
        send(1'b0, 8'hA4);
        send(1'b0, 8'h55);
        checks++;
        if (bus.sync_err !== 1'b1 || bus.locked !== 1'b0 || bus.valid !== 4'b0000 || bus.slot !== 2'd0) begin
            errors++; $display("[TB] FAIL missing_flags got se=%b locked=%b valid=%b slot=%0d want 1 0 0000 0",
                               bus.sync_err, bus.locked, bus.valid, bus.slot);
        end
        checks++;
        if ({bus.out0, bus.out1, bus.out2, bus.out3} !== 32'hA1A2A3A4 || bus.frame_done !== 1'b0) begin
            errors++; $display("[TB] FAIL missing_outs got %h fd=%b want a1a2a3a4 0",
                               {bus.out0, bus.out1, bus.out2, bus.out3}, bus.frame_done);
        end
        send(1'b1, 8'h66);
        checks++;
        if (bus.out0 !== 8'h66 || bus.locked !== 1'b1 || bus.sync_err !== 1'b0 || bus.slot !== 2'd1 || bus.out1 !== 8'hA2) begin
            errors++; $display("[TB] FAIL missing_relock got out0=%h locked=%b se=%b slot=%0d out1=%h want 66 1 0 1 a2",
                               bus.out0, bus.locked, bus.sync_err, bus.slot, bus.out1);
        end
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        rst            = 1'b1;
        bus.in_valid   = 1'b0;
        bus.frame_sync = 1'b0;
        bus.in_data    = 8'h00;
        test_reset();
        test_lock_frame();
        test_hunt_discard();
        test_gaps();
        test_early_sync();
        test_missing_sync();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
